// File: rtl/ov7670_stream_generator.sv
// Synthetic OV7670 RGB565 video source. Drives VSYNC/HREF/PCLK/D with test patterns
// so the capture path can be exercised without a sensor.
module ov7670_stream_generator #(
  parameter int LINES       = 140,
  parameter int COLUMNS     = 320,
  parameter int S_LINE      = 8,
  parameter int S_COLUMN    = 9,
  parameter int PCLK_DIV    = 2,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        iniciar_i,
  input  logic        continuo_i,
  input  logic [1:0]  modo_i,
  input  logic [15:0] cor_i,
  output logic        vsync_o,
  output logic        href_o,
  output logic        pclk_o,
  output logic [7:0]  d_o,
  output logic        ocupado_o,
  output logic        fim_frame_o,
  output logic [3:0]  db_estado_o
);
  // state    | meaning
  // REPOUSO  | idle, waiting for a start edge
  // VSYNC_AT | VSYNC high for VSYNC_LINES line-times
  // BACK     | vertical back porch before first line
  // LINHA    | HREF high, two bytes per pixel
  // BLANK_H  | horizontal blanking after each line
  // FIM      | one-clock end-of-frame pulse
  localparam int LINE_T  = 2*COLUMNS + H_BLANK;
  localparam int T_VS    = VSYNC_LINES*LINE_T;
  localparam int T_BK    = V_BACK*LINE_T;
  localparam int T_LN    = 2*COLUMNS;
  localparam int TW      = $clog2(T_VS + T_BK + T_LN + H_BLANK + 1);
  localparam int DW      = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
  localparam int BAR_W   = COLUMNS/8;
  localparam int BAR_D   = (BAR_W > 0) ? BAR_W : 1;
  localparam int BAR_LIM = 8*BAR_W;

  typedef enum logic [3:0] {
    REPOUSO  = 4'd0,
    VSYNC_AT = 4'd1,
    BACK     = 4'd2,
    LINHA    = 4'd3,
    BLANK_H  = 4'd4,
    FIM      = 4'd5
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       div_q;
  logic                pclk_q;
  logic                ini_q;
  logic                pend_q, pend_d;
  logic                cont_q, cont_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [S_LINE-1:0]   line_q, line_d;
  logic [S_COLUMN-1:0] col_q, col_d;
  logic                byte_q, byte_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [1:0]          modo_q, modo_d;
  logic [15:0]         cor_q, cor_d;
  logic                tick, start_edge;
  logic [15:0]         pix;
  logic [2:0]          bar_sel;

  assign tick       = (div_q == '0) && pclk_q;
  assign start_edge = iniciar_i && !ini_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q   <= DW'(PCLK_DIV-1);
      pclk_q  <= 1'b0;
      ini_q   <= 1'b0;
      state_q <= REPOUSO;
      pend_q  <= 1'b0;
      cont_q  <= 1'b0;
      tmr_q   <= '0;
      line_q  <= '0;
      col_q   <= '0;
      byte_q  <= 1'b0;
      cnt_q   <= '0;
      modo_q  <= '0;
      cor_q   <= '0;
    end else begin
      ini_q <= iniciar_i;
      if (div_q == '0) begin
        div_q  <= DW'(PCLK_DIV-1);
        pclk_q <= ~pclk_q;
      end else begin
        div_q <= div_q - DW'(1);
      end
      state_q <= state_d;
      pend_q  <= pend_d;
      cont_q  <= cont_d;
      tmr_q   <= tmr_d;
      line_q  <= line_d;
      col_q   <= col_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      modo_q  <= modo_d;
      cor_q   <= cor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cont_d  = cont_q;
    tmr_d   = tmr_q;
    line_d  = line_q;
    col_d   = col_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    modo_d  = modo_q;
    cor_d   = cor_q;
    case (state_q)
      REPOUSO: begin
        pend_d = pend_q || start_edge;
        if (tick && pend_q) begin
          state_d = VSYNC_AT;
          pend_d  = 1'b0;
          tmr_d   = TW'(T_VS-1);
          modo_d  = modo_i;
          cor_d   = cor_i;
          cnt_d   = '0;
        end
      end
      VSYNC_AT, BACK: begin
        if (tick) begin
          if (tmr_q != '0) begin
            tmr_d = tmr_q - TW'(1);
          end else if (state_q == VSYNC_AT) begin
            state_d = BACK;
            tmr_d   = TW'(T_BK-1);
          end else begin
            state_d = LINHA;
            tmr_d   = TW'(T_LN-1);
            line_d  = '0;
            col_d   = '0;
            byte_d  = 1'b0;
          end
        end
      end
      LINHA: begin
        if (tick) begin
          byte_d = ~byte_q;
          if (byte_q) begin
            col_d = col_q + S_COLUMN'(1);
            cnt_d = cnt_q + 16'd1;
          end
          if (tmr_q != '0) begin
            tmr_d = tmr_q - TW'(1);
          end else begin
            state_d = BLANK_H;
            tmr_d   = TW'(H_BLANK-1);
          end
        end
      end
      BLANK_H: begin
        if (tick) begin
          if (tmr_q != '0) begin
            tmr_d = tmr_q - TW'(1);
          end else if (line_q != S_LINE'(LINES-1)) begin
            state_d = LINHA;
            tmr_d   = TW'(T_LN-1);
            line_d  = line_q + S_LINE'(1);
            col_d   = '0;
            byte_d  = 1'b0;
          end else begin
            // Continuous mode decides and samples here so VSYNC rises on this tick
            state_d = FIM;
            cont_d  = continuo_i;
            if (continuo_i) begin
              modo_d = modo_i;
              cor_d  = cor_i;
              cnt_d  = '0;
            end
          end
        end
      end
      FIM: begin
        cont_d = 1'b0;
        if (cont_q) begin
          state_d = VSYNC_AT;
          tmr_d   = TW'(T_VS-1);
        end else begin
          state_d = REPOUSO;
        end
      end
      default: state_d = REPOUSO;
    endcase
  end

  assign bar_sel = 3'(32'(col_q) / BAR_D);

  always_comb begin
    pix = 16'h0000;
    case (modo_q)
      2'd0: begin
        if (32'(col_q) < BAR_LIM) begin
          case (bar_sel)
            3'd0: pix = 16'hFFFF;
            3'd1: pix = 16'hFFE0;
            3'd2: pix = 16'h07FF;
            3'd3: pix = 16'h07E0;
            3'd4: pix = 16'hF81F;
            3'd5: pix = 16'hF800;
            3'd6: pix = 16'h001F;
            default: pix = 16'h0000;
          endcase
        end
      end
      2'd1: pix = cnt_q;
      2'd2: pix = cor_q;
      default: pix = (col_q[3] ^ line_q[3]) ? ~cor_q : cor_q;
    endcase
  end

  assign vsync_o     = (state_q == VSYNC_AT) || ((state_q == FIM) && cont_q);
  assign href_o      = (state_q == LINHA);
  assign d_o         = href_o ? (byte_q ? pix[7:0] : pix[15:8]) : 8'h00;
  assign pclk_o      = pclk_q;
  assign ocupado_o   = (state_q != REPOUSO);
  assign fim_frame_o = (state_q == FIM);
  assign db_estado_o = state_q;
endmodule

// File: tb/tb_ov7670_stream_generator.sv
// Bench for ov7670_stream_generator: captures frames at PCLK rising edges from a small
// and a wider instance and compares them with a pattern model built from the frame rules.
module tb_ov7670_stream_generator;
  localparam int LA = 2,  CA = 4;
  localparam int LB = 10, CB = 16;
  localparam int HB = 2, VSL = 1, VBK = 1;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic clk = 1'b0, rst_n = 1'b1;
  logic ini_a = 1'b0, ini_b = 1'b0, cont_a = 1'b0, cont_b = 1'b0;
  logic [1:0]  modo = 2'd0;
  logic [15:0] cor = 16'h0000;
  logic vs_a, hr_a, pc_a, oc_a, fim_a, vs_b, hr_b, pc_b, oc_b, fim_b;
  logic [7:0] d_a, d_b;
  logic [3:0] st_a, st_b;

  int n_pass = 0, n_tot = 0;
  int fim_a_cnt = 0, fim_b_cnt = 0;
  logic [7:0] cap_q[$], exp_q[$];
  int r_len[4], r_vs[4], r_hp[4];
  bit r_to;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fim_a) fim_a_cnt <= fim_a_cnt + 1;
    if (fim_b) fim_b_cnt <= fim_b_cnt + 1;
  end

  ov7670_stream_generator #(.LINES(LA), .COLUMNS(CA), .S_LINE(8), .S_COLUMN(9), .PCLK_DIV(2),
    .H_BLANK(HB), .VSYNC_LINES(VSL), .V_BACK(VBK)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .iniciar_i(ini_a), .continuo_i(cont_a), .modo_i(modo),
    .cor_i(cor), .vsync_o(vs_a), .href_o(hr_a), .pclk_o(pc_a), .d_o(d_a), .ocupado_o(oc_a),
    .fim_frame_o(fim_a), .db_estado_o(st_a));

  ov7670_stream_generator #(.LINES(LB), .COLUMNS(CB), .S_LINE(8), .S_COLUMN(9), .PCLK_DIV(2),
    .H_BLANK(HB), .VSYNC_LINES(VSL), .V_BACK(VBK)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .iniciar_i(ini_b), .continuo_i(cont_b), .modo_i(modo),
    .cor_i(cor), .vsync_o(vs_b), .href_o(hr_b), .pclk_o(pc_b), .d_o(d_b), .ocupado_o(oc_b),
    .fim_frame_o(fim_b), .db_estado_o(st_b));

  function automatic int exp_len(input bit sel);
    int l = sel ? LB : LA, c = sel ? CB : CA;
    return (VSL + VBK + l) * (2*c + HB);
  endfunction

  function automatic logic [15:0] ref_pix(input int c_n, input int l, input int c,
                                          input logic [1:0] m, input logic [15:0] k);
    int bw = c_n / 8;
    case (m)
      2'd0: return (bw > 0 && c < 8*bw) ? BARS[c/bw] : 16'h0000;
      2'd1: return 16'(l*c_n + c);
      2'd2: return k;
      default: return ((((c >> 3) ^ (l >> 3)) & 1) != 0) ? ~k : k;
    endcase
  endfunction

  function automatic void build_exp(input bit sel, input logic [1:0] m, input logic [15:0] k);
    int l_n = sel ? LB : LA, c_n = sel ? CB : CA;
    logic [15:0] p;
    for (int l = 0; l < l_n; l++)
      for (int c = 0; c < c_n; c++) begin
        p = ref_pix(c_n, l, c, m, k);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
  endfunction

  function automatic int first_diff();
    if (cap_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (cap_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic smp(input bit sel, output logic v, output logic h, output logic o,
                     output logic [7:0] d);
    if (sel) begin @(posedge pc_b); v = vs_b; h = hr_b; o = oc_b; d = d_b; end
    else     begin @(posedge pc_a); v = vs_a; h = hr_a; o = oc_a; d = d_a; end
  endtask

  // Frame boundaries are VSYNC rising samples or ocupado falling
  task automatic cap(input bit sel, input int nfr);
    logic v, h, o, pv, ph;
    logic [7:0] d;
    int n = 0;
    cap_q.delete();
    r_to = 0;
    v = 1'b0;
    while (v !== 1'b1 && n < 300) begin smp(sel, v, h, o, d); n++; end
    if (v !== 1'b1) begin r_to = 1; return; end
    for (int f = 0; f < nfr; f++) begin
      r_len[f] = 0; r_vs[f] = 0; r_hp[f] = 0; ph = 1'b0;
      do begin
        r_len[f]++;
        if (v) r_vs[f]++;
        if (h) begin cap_q.push_back(d); if (!ph) r_hp[f]++; end
        ph = h; pv = v;
        smp(sel, v, h, o, d);
      end while (!(v && !pv) && o && r_len[f] < 2000);
      if (r_len[f] >= 2000) r_to = 1;
    end
  endtask

  task automatic pulse(input bit sel);
    @(negedge clk);
    if (sel) ini_b = 1'b1; else ini_a = 1'b1;
    repeat (3) @(negedge clk);
    ini_a = 1'b0; ini_b = 1'b0;
  endtask

  task automatic run_one(input bit sel, input logic [1:0] m, input logic [15:0] k);
    exp_q.delete();
    build_exp(sel, m, k);
    modo = m; cor = k;
    pulse(sel);
    cap(sel, 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tot++; if (pc_a !== 1'b0) $display("FAIL rst_pclk: got %b need 0", pc_a); else n_pass++;
    n_tot++; if (vs_a !== 1'b0) $display("FAIL rst_vsync: got %b need 0", vs_a); else n_pass++;
    n_tot++; if (hr_a !== 1'b0) $display("FAIL rst_href: got %b need 0", hr_a); else n_pass++;
    n_tot++; if (d_a !== 8'h00) $display("FAIL rst_d: got %h need 00", d_a); else n_pass++;
    n_tot++; if (oc_a !== 1'b0) $display("FAIL rst_ocupado: got %b need 0", oc_a); else n_pass++;
    n_tot++; if (fim_a !== 1'b0) $display("FAIL rst_fim: got %b need 0", fim_a); else n_pass++;
    n_tot++; if (st_a !== 4'd0) $display("FAIL rst_state: got %0d need 0", st_a); else n_pass++;
    n_tot++; if ({vs_b, hr_b, pc_b, oc_b, d_b, st_b} !== 16'h0)
      $display("FAIL rst_b_outputs: got %h need 0000", {vs_b, hr_b, pc_b, oc_b, d_b, st_b});
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_pclk_idle();
    logic prev;
    int rises = 0;
    @(negedge clk); prev = pc_a;
    repeat (40) begin @(negedge clk); if (pc_a && !prev) rises++; prev = pc_a; end
    n_tot++; if (rises !== 10) $display("FAIL pclk_idle: rises %0d need 10", rises); else n_pass++;
    n_tot++; if (st_a !== 4'd0) $display("FAIL idle_state: got %0d need 0", st_a); else n_pass++;
  endtask

  task automatic test_solid();
    int f0 = fim_a_cnt, dd;
    run_one(1'b0, 2'd2, 16'hF800);
    n_tot++; if (r_to !== 1'b0) $display("FAIL solid_timeout: got %b need 0", r_to); else n_pass++;
    n_tot++; if (r_vs[0] !== 10) $display("FAIL solid_vsync_len: got %0d need 10", r_vs[0]); else n_pass++;
    n_tot++; if (r_hp[0] !== 2) $display("FAIL solid_href_pulses: got %0d need 2", r_hp[0]); else n_pass++;
    n_tot++; if (r_len[0] !== 40) $display("FAIL solid_frame_len: got %0d need 40", r_len[0]); else n_pass++;
    dd = first_diff();
    n_tot++; if (dd != -1) $display("FAIL solid_bytes: diff at %0d size %0d need %0d", dd, cap_q.size(), exp_q.size()); else n_pass++;
    n_tot++; if (fim_a_cnt - f0 !== 1) $display("FAIL solid_fim: got %0d need 1", fim_a_cnt - f0); else n_pass++;
    n_tot++; if (oc_a !== 1'b0) $display("FAIL solid_ocupado_end: got %b need 0", oc_a); else n_pass++;
  endtask

  task automatic test_counter();
    int dd;
    for (int rep = 0; rep < 2; rep++) begin
      run_one(1'b0, 2'd1, 16'($urandom));
      dd = first_diff();
      n_tot++; if (dd != -1) $display("FAIL counter_bytes[%0d]: diff at %0d got %h need %h", rep, dd, (dd >= 0) ? cap_q[dd] : 8'h0, (dd >= 0) ? exp_q[dd] : 8'h0); else n_pass++;
    end
  endtask

  task automatic test_wide();
    int dd;
    run_one(1'b1, 2'd0, 16'h1234);
    n_tot++; if (r_vs[0] !== 34) $display("FAIL bars_vsync_len: got %0d need 34", r_vs[0]); else n_pass++;
    n_tot++; if (r_hp[0] !== LB) $display("FAIL bars_href_pulses: got %0d need %0d", r_hp[0], LB); else n_pass++;
    n_tot++; if (r_len[0] !== exp_len(1'b1)) $display("FAIL bars_frame_len: got %0d need %0d", r_len[0], exp_len(1'b1)); else n_pass++;
    dd = first_diff();
    n_tot++; if (dd != -1) $display("FAIL bars_bytes: diff at %0d size %0d need %0d", dd, cap_q.size(), exp_q.size()); else n_pass++;
    run_one(1'b1, 2'd3, 16'h001F);
    dd = first_diff();
    n_tot++; if (dd != -1) $display("FAIL checker_bytes: diff at %0d size %0d need %0d", dd, cap_q.size(), exp_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    bit sel;
    logic [1:0] m;
    logic [15:0] k;
    int dd;
    for (int it = 0; it < 6; it++) begin
      sel = 1'($urandom_range(0, 1));
      m = 2'($urandom_range(0, 3));
      k = 16'($urandom);
      run_one(sel, m, k);
      dd = first_diff();
      n_tot++; if (dd != -1) $display("FAIL rand_bytes[%0d] dut%0d modo %0d cor %h: diff at %0d", it, sel, m, k, dd); else n_pass++;
      n_tot++; if (r_len[0] !== exp_len(sel)) $display("FAIL rand_len[%0d]: got %0d need %0d", it, r_len[0], exp_len(sel)); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int f0 = fim_a_cnt, dd;
    logic [15:0] c0 = 16'($urandom), c1 = ~c0;
    exp_q.delete();
    build_exp(1'b0, 2'd3, c0);
    build_exp(1'b0, 2'd3, c1);
    build_exp(1'b0, 2'd3, c1);
    modo = 2'd3; cor = c0; cont_a = 1'b1;
    fork
      cap(1'b0, 3);
      begin
        pulse(1'b0);
        repeat (100) @(negedge clk);
        cor = c1;
        pulse(1'b0);
        for (int i = 0; i < 2000 && fim_a_cnt < f0 + 2; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        cont_a = 1'b0;
      end
    join
    repeat (60) @(negedge clk);
    n_tot++; if (r_to !== 1'b0) $display("FAIL b2b_timeout: got %b need 0", r_to); else n_pass++;
    for (int f = 0; f < 3; f++) begin
      n_tot++; if (r_len[f] !== 40) $display("FAIL b2b_period[%0d]: got %0d need 40", f, r_len[f]); else n_pass++;
    end
    dd = first_diff();
    n_tot++; if (dd != -1) $display("FAIL b2b_bytes: diff at %0d size %0d need %0d", dd, cap_q.size(), exp_q.size()); else n_pass++;
    n_tot++; if (fim_a_cnt - f0 !== 3) $display("FAIL b2b_fim_count: got %0d need 3", fim_a_cnt - f0); else n_pass++;
    n_tot++; if (oc_a !== 1'b0) $display("FAIL b2b_stopped: ocupado %b need 0", oc_a); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int f0, rises = 0, n = 0, dd;
    logic v, h, o, ph = 1'b0;
    logic [7:0] d;
    modo = 2'd2; cor = 16'hFFFF;
    pulse(1'b0);
    while (rises < 2 && n < 200) begin
      smp(1'b0, v, h, o, d);
      if (h && !ph) rises++;
      ph = h; n++;
    end
    n_tot++; if (rises !== 2) $display("FAIL mid_reach_line1: href rises %0d need 2", rises); else n_pass++;
    f0 = fim_a_cnt;
    @(negedge clk); rst_n = 1'b0; #1;
    n_tot++; if ({vs_a, hr_a, pc_a, oc_a} !== 4'b0) $display("FAIL mid_rst_ctl: got %b need 0000", {vs_a, hr_a, pc_a, oc_a}); else n_pass++;
    n_tot++; if (d_a !== 8'h00) $display("FAIL mid_rst_d: got %h need 00", d_a); else n_pass++;
    n_tot++; if (st_a !== 4'd0) $display("FAIL mid_rst_state: got %0d need 0", st_a); else n_pass++;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_tot++; if (fim_a_cnt !== f0) $display("FAIL mid_no_fim: got %0d need %0d", fim_a_cnt, f0); else n_pass++;
    run_one(1'b0, 2'd1, 16'h0);
    dd = first_diff();
    n_tot++; if (dd != -1 || r_len[0] !== 40) $display("FAIL mid_after_frame: diff %0d len %0d need -1 and 40", dd, r_len[0]); else n_pass++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pclk_idle();
    test_solid();
    test_counter();
    test_wide();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
